// File: rtl/i2s_multi_ch_gen_pkg.sv
// Shared encodings for the multi-channel I2S/LJ/TDM serializer: bus modes and controller states.
package i2s_multi_ch_gen_pkg;

  typedef enum logic [1:0] {
    ModeI2s = 2'd0,
    ModeLj  = 2'd1,
    ModeTdm = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  // The reserved encoding 3 behaves as I2S.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return ModeLj;
      2'd2:    return ModeTdm;
      default: return ModeI2s;
    endcase
  endfunction

endpackage

// File: rtl/sync_sample_fifo.sv
// Single-clock sample FIFO with first-word-fall-through read data and an occupancy count.
module sync_sample_fifo #(
  parameter int unsigned pWidth = 16,
  parameter int unsigned pDepth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [pWidth-1:0]         push_data,
  input  logic                      pop,
  output logic [pWidth-1:0]         pop_data,
  output logic [$clog2(pDepth):0]   count,
  output logic                      full
);

  localparam int unsigned PtrW = $clog2(pDepth);
  localparam logic [PtrW:0] CntFull = pDepth[PtrW:0];

  logic [pWidth-1:0] mem_q [pDepth];
  logic [PtrW-1:0]   wr_q, rd_q;
  logic [PtrW:0]     cnt_q;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CntFull);
  assign do_push = push && !full;
  assign do_pop  = pop && (cnt_q != '0);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_q];
  assign count    = cnt_q;

endmodule

// File: rtl/i2s_multi_ch_gen.sv
// Multi-channel audio serializer: FIFO-fed frames sent as I2S, left-justified or TDM (DSP-A),
// with silence frames on underrun and a clean drain when the run request drops.
module i2s_multi_ch_gen
  import i2s_multi_ch_gen_pkg::*;
#(
  parameter int unsigned pChannels    = 2,
  parameter int unsigned pSampleWidth = 16,
  parameter int unsigned pSlotWidth   = 32,
  parameter int unsigned pBclkDiv     = 4,
  parameter int unsigned pFifoDepth   = 16
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iEnable,
  input  logic [1:0]                    iMode,
  input  logic [pSampleWidth-1:0]       iAudioData,
  input  logic                          iAudioVd,
  output logic                          oAudioRdy,
  output logic                          oI2S_MCLK,
  output logic                          oI2S_BCLK,
  output logic                          oI2S_LRCLK,
  output logic                          oI2S_SDATA,
  output logic [$clog2(pFifoDepth):0]   oFifoCount,
  output logic [15:0]                   oUnderrunCnt,
  output logic                          oBusy
);

  localparam int unsigned DivW  = (pBclkDiv > 1) ? $clog2(pBclkDiv) : 1;
  localparam int unsigned BitW  = (pSlotWidth > 1) ? $clog2(pSlotWidth) : 1;
  localparam int unsigned SlotW = $clog2(pChannels);
  localparam int unsigned LdW   = SlotW + 1;
  localparam int unsigned CntW  = $clog2(pFifoDepth) + 1;

  localparam logic [DivW-1:0]  DivLast   = DivW'(pBclkDiv - 1);
  localparam logic [BitW-1:0]  BitLast   = BitW'(pSlotWidth - 1);
  localparam logic [SlotW-1:0] SlotLast  = SlotW'(pChannels - 1);
  localparam logic [SlotW-1:0] SlotHalf  = SlotW'(pChannels / 2);
  localparam logic [LdW-1:0]   LdDone    = LdW'(pChannels);
  localparam logic [CntW-1:0]  FrameNeed = CntW'(pChannels);

  state_e state_q, state_d;
  mode_e  mode_q, mode_cur;

  logic [DivW-1:0]         div_q;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [SlotW-1:0]        slot_q, slot_d;
  logic [LdW-1:0]          ld_q;
  logic [15:0]             urun_q;
  logic [pSampleWidth-1:0] buf_q [pChannels];
  logic [pSampleWidth-1:0] fifo_data, smp;
  logic [pSlotWidth-1:0]   word;
  logic [CntW-1:0]         fifo_count;
  logic                    fifo_full;
  logic mclk_q, bclk_q, lrclk_q, sdata_q, s_q, tail_q, zero_q;
  logic busy, tick, fall, start, frame_end, cont, delayed, have_data;
  logic new_frame, adv, go_tail, go_idle, pop, s_first, s_adv;

  sync_sample_fifo #(
    .pWidth (pSampleWidth),
    .pDepth (pFifoDepth)
  ) u_fifo (
    .clk       (iCLK),
    .rst       (iRST),
    .push      (iAudioVd && oAudioRdy),
    .push_data (iAudioData),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  always_comb begin
    busy      = (state_q != StIdle);
    tick      = (div_q == DivLast);
    fall      = busy && tick && bclk_q;
    start     = (state_q == StIdle) && tick && !bclk_q && iEnable;
    mode_cur  = start ? decode_mode(iMode) : mode_q;
    delayed   = (mode_cur != ModeLj);
    frame_end = (bit_q == BitLast) && (slot_q == SlotLast);
    cont      = (state_q == StRun) || iEnable;
    have_data = (fifo_count >= FrameNeed);
    new_frame = start || (fall && !tail_q && frame_end && cont);
    adv       = fall && !tail_q && !frame_end;
    go_tail   = fall && !tail_q && frame_end && !cont && delayed;
    go_idle   = fall && (tail_q || (frame_end && !cont && !delayed));
    pop       = (new_frame && have_data) || (ld_q != LdDone);
    bit_d     = bit_q + 1'b1;
    slot_d    = slot_q;
    if (bit_q == BitLast) begin
      bit_d  = '0;
      slot_d = slot_q + 1'b1;
    end
    // Slot word: sample left-aligned, padding bits zero, sent MSB first.
    smp     = buf_q[slot_d];
    word    = pSlotWidth'(smp) << (pSlotWidth - pSampleWidth);
    s_adv   = !zero_q && word[BitLast - bit_d];
    s_first = have_data && fifo_data[pSampleWidth-1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (!iEnable) state_d = StDrain;
      StDrain: begin
        if (tail_q) begin
          if (fall) state_d = StIdle;
        end else if (iEnable) begin
          state_d = StRun;
        end else if (go_idle) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
      mode_q  <= ModeI2s;
      div_q   <= '0;
      bit_q   <= '0;
      slot_q  <= '0;
      ld_q    <= LdDone;
      urun_q  <= '0;
      mclk_q  <= 1'b0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      s_q     <= 1'b0;
      tail_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mclk_q  <= !mclk_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      if (busy && tick) bclk_q <= !bclk_q;
      if (start) mode_q <= mode_cur;
      if (new_frame && have_data) ld_q <= LdW'(1);
      else if (ld_q != LdDone)    ld_q <= ld_q + 1'b1;
      // s_q holds the undelayed stream bit so delayed modes can emit it one BCLK later.
      if (new_frame) begin
        bit_q   <= '0;
        slot_q  <= '0;
        zero_q  <= !have_data;
        if (!have_data && urun_q != 16'hFFFF) urun_q <= urun_q + 1'b1;
        s_q     <= s_first;
        sdata_q <= delayed ? s_q : s_first;
        lrclk_q <= (mode_cur == ModeTdm);
      end else if (adv) begin
        bit_q   <= bit_d;
        slot_q  <= slot_d;
        s_q     <= s_adv;
        sdata_q <= delayed ? s_q : s_adv;
        lrclk_q <= (mode_cur != ModeTdm) && (slot_d >= SlotHalf);
      end else if (go_tail) begin
        tail_q  <= 1'b1;
        s_q     <= 1'b0;
        sdata_q <= s_q;
        lrclk_q <= 1'b0;
      end else if (go_idle) begin
        tail_q  <= 1'b0;
        bit_q   <= '0;
        slot_q  <= '0;
        s_q     <= 1'b0;
        sdata_q <= 1'b0;
        lrclk_q <= 1'b0;
      end
    end
  end

  // Slot 0 is captured on the frame-start pop, the rest on the following cycles.
  always_ff @(posedge iCLK) begin
    if (new_frame && have_data)  buf_q[0] <= fifo_data;
    else if (ld_q != LdDone)     buf_q[ld_q[SlotW-1:0]] <= fifo_data;
  end

  assign oAudioRdy    = !fifo_full && !iRST;
  assign oI2S_MCLK    = mclk_q;
  assign oI2S_BCLK    = bclk_q;
  assign oI2S_LRCLK   = lrclk_q;
  assign oI2S_SDATA   = sdata_q;
  assign oFifoCount   = fifo_count;
  assign oUnderrunCnt = urun_q;
  assign oBusy        = busy;

endmodule

// File: tb/tb_i2s_multi_ch_gen.sv
// Directed bench: stereo instance for I2S/LJ/TDM frames, underrun, stop, reset and full FIFO;
// 8-channel TDM instance for slot ordering.
module tb_i2s_multi_ch_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_a = 0, vd_a = 0, rdy_a, mclk_a, bclk_a, lr_a, sd_a, busy_a;
  logic [1:0]  mode_a = 0;
  logic [15:0] data_a = 0, urun_a;
  logic [4:0]  cnt_a;
  logic        en_b = 0, vd_b = 0, rdy_b, mclk_b, bclk_b, lr_b, sd_b, busy_b;
  logic [1:0]  mode_b = 0;
  logic [15:0] data_b = 0, urun_b;
  logic [4:0]  cnt_b;

  i2s_multi_ch_gen u_dut_a (
    .iCLK (clk), .iRST (rst), .iEnable (en_a), .iMode (mode_a),
    .iAudioData (data_a), .iAudioVd (vd_a), .oAudioRdy (rdy_a),
    .oI2S_MCLK (mclk_a), .oI2S_BCLK (bclk_a), .oI2S_LRCLK (lr_a), .oI2S_SDATA (sd_a),
    .oFifoCount (cnt_a), .oUnderrunCnt (urun_a), .oBusy (busy_a)
  );

  i2s_multi_ch_gen #(
    .pChannels (8), .pSampleWidth (16), .pSlotWidth (32), .pBclkDiv (2), .pFifoDepth (16)
  ) u_dut_b (
    .iCLK (clk), .iRST (rst), .iEnable (en_b), .iMode (mode_b),
    .iAudioData (data_b), .iAudioVd (vd_b), .oAudioRdy (rdy_b),
    .oI2S_MCLK (mclk_b), .oI2S_BCLK (bclk_b), .oI2S_LRCLK (lr_b), .oI2S_SDATA (sd_b),
    .oFifoCount (cnt_b), .oUnderrunCnt (urun_b), .oBusy (busy_b)
  );

  // {lrclk, sdata} captured at every BCLK rising edge.
  logic [1:0] log_a[$];
  logic [1:0] log_b[$];
  logic prev_a = 1'b0, prev_b = 1'b0;
  always @(negedge clk) begin
    if (bclk_a && !prev_a) log_a.push_back({lr_a, sd_a});
    if (bclk_b && !prev_b) log_b.push_back({lr_b, sd_b});
    prev_a <= bclk_a;
    prev_b <= bclk_b;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int which, input logic [15:0] d);
    @(negedge clk);
    if (which == 0) begin data_a = d; vd_a = 1'b1; end
    else begin data_b = d; vd_b = 1'b1; end
    @(negedge clk);
    vd_a = 1'b0;
    vd_b = 1'b0;
  endtask

  task automatic wait_busy(input int which, input logic want, input int limit, input string name);
    int n = 0;
    logic b;
    b = (which == 0) ? busy_a : busy_b;
    while (b !== want && n < limit) begin
      @(negedge clk);
      n++;
      b = (which == 0) ? busy_a : busy_b;
    end
    check(name, b, want);
  endtask

  // One frame: request run, drop the request as soon as it starts, and scramble the mode input.
  task automatic run_frame(input int which, input logic [1:0] m, input int limit);
    if (which == 0) begin log_a.delete(); mode_a = m; en_a = 1'b1; end
    else begin log_b.delete(); mode_b = m; en_b = 1'b1; end
    wait_busy(which, 1'b1, 64, "busy_rise");
    if (which == 0) begin en_a = 1'b0; mode_a = m ^ 2'b10; end
    else begin en_b = 1'b0; mode_b = m ^ 2'b10; end
    wait_busy(which, 1'b0, limit, "busy_fall");
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] left;
    logic [15:0] right;
    int          delay;
    int          len;
    logic [63:0] lr;
  } vec_t;

  vec_t vecs[4];
  logic [63:0]  act_sd, act_lr, exp_sd;
  logic [255:0] act_sd_b, act_lr_b, exp_sd_b, exp_lr_b;
  logic         m0a, m0b;

  initial begin
    vecs[0] = '{2'd0, 16'h8001, 16'h7FFF, 1, 65, 64'h0000_0000_FFFF_FFFF};
    vecs[1] = '{2'd1, 16'h8001, 16'h7FFF, 0, 64, 64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{2'd3, 16'hA5C3, 16'h0F0F, 1, 65, 64'h0000_0000_FFFF_FFFF};
    vecs[3] = '{2'd2, 16'h1234, 16'hFEDC, 1, 65, 64'h8000_0000_0000_0000};

    repeat (3) @(negedge clk);
    check("reset_outputs", {mclk_a, bclk_a, lr_a, sd_a, busy_a, rdy_a}, 6'd0);
    check("reset_counts", {cnt_a, urun_a}, 21'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_reset", {rdy_a, rdy_b}, 2'b11);

    @(negedge clk);
    m0a = mclk_a;
    m0b = mclk_b;
    @(negedge clk);
    check("mclk_toggle", {mclk_a, mclk_b}, {~m0a, ~m0b});

    for (int r = 0; r < 4; r++) begin
      push(0, vecs[r].left);
      push(0, vecs[r].right);
      run_frame(0, vecs[r].mode, 2000);
      exp_sd = {vecs[r].left, 16'h0000, vecs[r].right, 16'h0000};
      if (vecs[r].delay != 0) exp_sd = exp_sd >> 1;
      act_sd = '0;
      act_lr = '0;
      for (int p = 0; p < 64 && p < log_a.size(); p++) begin
        act_lr[63-p] = log_a[p][1];
        act_sd[63-p] = log_a[p][0];
      end
      check($sformatf("row%0d_len", r), log_a.size(), vecs[r].len);
      check($sformatf("row%0d_sdata", r), act_sd, exp_sd);
      check($sformatf("row%0d_lrclk", r), act_lr, vecs[r].lr);
      check($sformatf("row%0d_count_urun", r), {cnt_a, urun_a}, 21'd0);
    end

    // Underrun: a single queued sample is not enough for a stereo frame.
    push(0, 16'hFFFF);
    run_frame(0, 2'd0, 2000);
    act_sd = '0;
    for (int p = 0; p < 64 && p < log_a.size(); p++) act_sd[63-p] = log_a[p][0];
    check("urun_len", log_a.size(), 65);
    check("urun_silence", act_sd, 64'd0);
    check("urun_cnt", urun_a, 16'd1);
    check("urun_fifo_kept", cnt_a, 5'd1);

    // Reset in the middle of a running frame.
    push(0, 16'h5555);
    log_a.delete();
    mode_a = 2'd0;
    en_a = 1'b1;
    begin
      int n = 0;
      while (log_a.size() < 10 && n < 400) begin @(negedge clk); n++; end
    end
    check("midframe_reached", log_a.size() >= 10, 1'b1);
    check("midframe_busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    check("midreset_outputs", {bclk_a, lr_a, sd_a, busy_a, rdy_a}, 5'd0);
    check("midreset_counts", {cnt_a, urun_a}, 21'd0);
    @(negedge clk);
    en_a = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset_rdy", rdy_a, 1'b1);

    // Full FIFO: the 17th push is dropped.
    for (int i = 0; i < 16; i++) push(0, 16'(i + 1));
    check("full_rdy", rdy_a, 1'b0);
    check("full_count", cnt_a, 5'd16);
    push(0, 16'hDEAD);
    check("full_drop_count", cnt_a, 5'd16);
    check("full_drop_rdy", rdy_a, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("full_cleared", {rdy_a, cnt_a}, 6'b1_00000);

    // Eight-slot TDM frame.
    for (int k = 1; k <= 8; k++) push(1, 16'(k));
    check("tdm_fill", cnt_b, 5'd8);
    run_frame(1, 2'd2, 4000);
    exp_sd_b = '0;
    for (int k = 0; k < 8; k++) exp_sd_b[255 - 32*k -: 16] = 16'(k + 1);
    exp_sd_b = exp_sd_b >> 1;
    exp_lr_b = '0;
    exp_lr_b[255] = 1'b1;
    act_sd_b = '0;
    act_lr_b = '0;
    for (int p = 0; p < 256 && p < log_b.size(); p++) begin
      act_lr_b[255-p] = log_b[p][1];
      act_sd_b[255-p] = log_b[p][0];
    end
    check("tdm_len", log_b.size(), 257);
    check("tdm_sdata", act_sd_b, exp_sd_b);
    check("tdm_lrclk", act_lr_b, exp_lr_b);
    check("tdm_count_urun", {cnt_b, urun_b}, 21'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_multi_ch_gen.md
I2S_MULTI_CH_GEN -- requirements
Module: i2s_multi_ch_gen

Interface
REQ-001 SHALL have parameter pChannels, default 2, slots per frame; even values 2..8 only.
REQ-002 SHALL have parameter pSampleWidth, default 16, bits per sample; range 8..32, and pSampleWidth <= pSlotWidth.
REQ-003 SHALL have parameter pSlotWidth, default 32, BCLK periods per slot.
REQ-004 SHALL have parameter pBclkDiv, default 4, iCLK cycles per BCLK half-period; minimum 1.
REQ-005 SHALL have parameter pFifoDepth, default 16, sample FIFO entries; power of 2 and >= 2*pChannels.
REQ-006 SHALL have port iCLK, input, 1 bit: sole clock; one clock, and reset is asynchronous and active-high.
REQ-007 SHALL have port iRST, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port iEnable, input, 1 bit: run request.
REQ-009 SHALL have port iMode, input, 2 bits: 0 = I2S, 1 = left-justified, 2 = TDM (DSP-A), 3 = reserved and treated as 0.
REQ-010 SHALL have port iAudioData, input, pSampleWidth bits: sample for the next channel in order.
REQ-011 SHALL have port iAudioVd, input, 1 bit: sample valid.
REQ-012 SHALL have port oAudioRdy, output, 1 bit: FIFO not full.
REQ-013 SHALL have ports oI2S_MCLK, oI2S_BCLK, oI2S_LRCLK and oI2S_SDATA, output, 1 bit each: serial bus.
REQ-014 SHALL have port oFifoCount, output, log2(pFifoDepth)+1 bits: FIFO occupancy.
REQ-015 SHALL have port oUnderrunCnt, output, 16 bits: count of frames sent as silence.
REQ-016 SHALL have port oBusy, output, 1 bit: high while not IDLE.

Function
REQ-017 SHALL push a sample when iAudioVd && oAudioRdy; iAudioVd while full is dropped with no overflow side effect; push and pop in the same cycle leave the count unchanged.
REQ-018 SHALL toggle oI2S_MCLK every iCLK cycle (iCLK/2), free-running out of reset.
REQ-019 SHALL, outside IDLE, toggle BCLK each time the divider counter wraps at pBclkDiv-1; the falling edge is the serial update point.
REQ-020 SHALL use states IDLE, RUN and DRAIN: IDLE->RUN on iEnable at a divider wrap with BCLK low; RUN->DRAIN when iEnable falls; DRAIN->IDLE after the last BCLK falling edge of the current frame; DRAIN->RUN if iEnable reasserts before the frame ends.
REQ-021 SHALL latch iMode only on the IDLE->RUN transition; mode changes while running are ignored.
REQ-022 SHALL, at each frame start, pop pChannels samples into a frame buffer if oFifoCount >= pChannels; otherwise it pops nothing, sends zeros for the whole frame, and increments oUnderrunCnt (saturating at 0xFFFF).
REQ-023 SHALL place each slot MSB first, sample left-aligned, with the remaining pSlotWidth-pSampleWidth bits zero; slot k carries the k-th popped sample.
REQ-024 SHALL, in I2S mode, drive LRCLK low for slots 0..pChannels/2-1 and high for the rest, changing at slot boundaries, with SDATA delayed one BCLK relative to the slot stream.
REQ-025 SHALL, in left-justified mode, drive LRCLK as in I2S mode with no data delay.
REQ-026 SHALL, in TDM mode, drive LRCLK high for exactly the first BCLK period of each frame, with SDATA delayed one BCLK.
REQ-027 SHALL, with a one-bit delay, carry the LSB of the last slot into the first BCLK of the next frame; on a DRAIN->IDLE exit it emits that bit during one extra BCLK period before stopping.
REQ-028 SHALL, in IDLE, hold BCLK, LRCLK and SDATA low while the FIFO continues to accept samples.

Reset
REQ-029 SHALL, on iRST, asynchronously clear the FIFO pointers, oFifoCount, oUnderrunCnt, divider, bit and slot counters, state (IDLE), and all serial outputs (0), and hold oAudioRdy at 0.
REQ-030 SHALL drive oAudioRdy to 1 in the first cycle after iRST deasserts; a reset mid-frame truncates the frame immediately.

Structure
REQ-031 SHALL take the mode encodings (I2S, LJ, TDM) and state encodings from the shared synthesizer package.
REQ-032 SHALL implement the sample FIFO as one sub-module, sync_sample_fifo, reusable for the other audio blocks; the serializer stays in this module.

Verification
REQ-033 SHALL verify defaults in I2S mode: push 0x8001 then 0x7FFF, enable -> left-slot MSB on BCLK 1 after the LRCLK fall, the 0x8001 bits then 16 zeros, LRCLK high for the 0x7FFF slot.
REQ-034 SHALL verify LJ mode: the same data -> MSB coincides with the first BCLK of the slot, LRCLK unchanged.
REQ-035 SHALL verify pChannels=8 in TDM mode: push 8 samples 0x01..0x08 -> a 1-BCLK LRCLK pulse, then slot k carries k in 256 BCLKs per frame.
REQ-036 SHALL verify underrun: enable with 1 sample queued -> a zero frame, oUnderrunCnt=1, FIFO count still 1.
REQ-037 SHALL verify full FIFO: 17 pushes with depth 16 -> oAudioRdy=0 after the 16th push, the 17th is dropped, and oFifoCount=16.
REQ-038 SHALL verify stop and reset: deassert iEnable mid-frame -> the frame completes plus 1 BCLK, oBusy falls; iRST asserted mid-frame -> outputs are 0 in the same cycle.
